// File: rtl/dmux8way_deser_if.sv
// dmux8way_deser_if
// Bundles the lane-serial input handshake, the parallel word output
// handshake and the status outputs of the 8-way deserialiser.
//   in_data/in_sof/in_valid/in_ready : lane-serial input, one lane per beat
//   out_data/out_valid/out_ready     : assembled 8-lane word, lane 0 in the MSBs
//   slot                             : index of the next lane to be written
//   frame_err                        : one-cycle pulse when a frame is restarted early
// The slave modport is the deserialiser's view; master is the view of
// whatever drives the link and consumes the words.
interface dmux8way_deser_if #(
    parameter int LANE_W = 1
);
    logic [LANE_W-1:0]   in_data;
    logic                in_sof;
    logic                in_valid;
    logic                in_ready;
    logic [8*LANE_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          slot;
    logic                frame_err;

    modport slave (
        input  in_data, in_sof, in_valid, out_ready,
        output in_ready, out_data, out_valid, slot, frame_err
    );

    modport master (
        output in_data, in_sof, in_valid, out_ready,
        input  in_ready, out_data, out_valid, slot, frame_err
    );
endinterface

// File: rtl/dmux8way_deser.sv
// dmux8way_deser
// Receive-side counterpart of the 8-way selector. Lanes arrive one per
// accepted beat and are written into 8 assembly slots chosen by a 3-bit
// slot counter; once lane 7 is accepted the whole word is registered onto
// a valid/ready output.
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : dmux8way_deser_if.slave (input lanes, output word, slot, frame_err)
module dmux8way_deser #(
    parameter int LANE_W = 1
) (
    input  logic               clk,
    input  logic               reset,
    dmux8way_deser_if.slave    bus
);

    logic [LANE_W-1:0]   lane_q [8];
    logic [LANE_W-1:0]   lane_d [8];
    logic [2:0]          slot_q, slot_d;
    logic [8*LANE_W-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                in_ready_c;
    logic                accept;

    // The only reason to refuse a beat is a final lane that has nowhere to
    // go: the output register is still full and the consumer is not taking
    // it this cycle. Earlier lanes never touch the output register.
    always_comb begin
        in_ready_c = !(slot_q == 3'd7 && out_valid_q && !bus.out_ready);
        accept     = bus.in_valid && in_ready_c;
    end

    // Next-state for the assembly lanes, slot counter and output register.
    // A consumer handshake frees the output, but a completion in the same
    // cycle refills it, so there is never a bubble between words.
    // An early sof restarts assembly at lane 0 and drops the partial word;
    // stale lanes are harmless because out_data only loads on completion.
    always_comb begin
        lane_d      = lane_q;
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (bus.in_sof && slot_q != 3'd0) begin
                lane_d[0]   = bus.in_data;
                slot_d      = 3'd1;
                frame_err_d = 1'b1;
            end else begin
                lane_d[slot_q] = bus.in_data;
                slot_d         = slot_q + 3'd1;
                if (slot_q == 3'd7) begin
                    out_data_d  = {lane_q[0], lane_q[1], lane_q[2], lane_q[3],
                                   lane_q[4], lane_q[5], lane_q[6], bus.in_data};
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset throws away any partial or pending word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q      <= '{default: '0};
            slot_q      <= 3'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            slot_q      <= slot_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_dmux8way_deser.sv
// tb_dmux8way_deser
// Two instances: LANE_W=1 for the single-bit frame, LANE_W=4 for the rest.
// Words expected from the LANE_W=4 instance are queued when their frame is
// driven and popped whenever that instance completes an output handshake.
module tb_dmux8way_deser;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dmux8way_deser_if #(.LANE_W(1)) bus1 ();
    dmux8way_deser_if #(.LANE_W(4)) bus4 ();

    dmux8way_deser #(.LANE_W(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    dmux8way_deser #(.LANE_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int          compared = 0;
    int          failed   = 0;
    int          cycles   = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_word;
    bit          acc4;
    bit          rand_ready = 1'b0;

    // Watchdog so the run always ends even if a wait loop is broken.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock: observe at the falling edge (acceptance and output
    // handshake about to happen), then return just after the rising edge
    // so the caller can drive the next inputs.
    task automatic step();
        @(negedge clk);
        acc4 = bus4.in_valid && bus4.in_ready;
        if (!reset && bus4.out_valid && bus4.out_ready) begin
            compared++;
            if (sb.size() == 0) begin
                failed++;
                $display("[TB] FAIL sb_extra: got word %h, expected no word", bus4.out_data);
            end else begin
                exp_word = sb.pop_front();
                if (bus4.out_data !== exp_word) begin
                    failed++;
                    $display("[TB] FAIL sb_word: got %h, expected %h", bus4.out_data, exp_word);
                end
            end
        end
        @(posedge clk);
        #1;
        cycles++;
        if (rand_ready) bus4.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle4();
        bus4.in_valid = 1'b0;
        bus4.in_sof   = 1'b0;
    endtask

    // Present one lane and hold it until accepted (bounded).
    task automatic send_beat4(input logic [3:0] d, input logic sof);
        bit done = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = d;
        bus4.in_sof   = sof;
        for (int n = 0; n < 64 && !done; n++) begin
            step();
            done = acc4;
        end
        if (!done) begin
            compared++;
            failed++;
            $display("[TB] FAIL beat_timeout: lane %h not accepted in 64 cycles, expected acceptance", d);
        end
    endtask

    task automatic send_frame4(input logic [31:0] word, input logic sof_first, input bit gaps);
        sb.push_back(word);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                idle4();
                repeat ($urandom_range(1, 3)) step();
            end
            send_beat4(word[31-4*i -: 4], (i == 0) ? sof_first : 1'b0);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        bus1.in_valid = 1'b0; bus1.in_sof = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_sof = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared += 5;
        if (bus4.slot !== 3'd0)       begin failed++; $display("[TB] FAIL rst_slot4: got %0d, expected 0", bus4.slot); end
        if (bus4.out_valid !== 1'b0)  begin failed++; $display("[TB] FAIL rst_valid4: got %b, expected 0", bus4.out_valid); end
        if (bus4.out_data !== 32'h0)  begin failed++; $display("[TB] FAIL rst_data4: got %h, expected 0", bus4.out_data); end
        if (bus4.frame_err !== 1'b0)  begin failed++; $display("[TB] FAIL rst_ferr4: got %b, expected 0", bus4.frame_err); end
        if (bus1.out_valid !== 1'b0)  begin failed++; $display("[TB] FAIL rst_valid1: got %b, expected 0", bus1.out_valid); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        compared += 2;
        if (bus4.in_ready !== 1'b1)   begin failed++; $display("[TB] FAIL rst_ready4: got %b, expected 1", bus4.in_ready); end
        if (bus1.in_ready !== 1'b1)   begin failed++; $display("[TB] FAIL rst_ready1: got %b, expected 1", bus1.in_ready); end
    endtask

    task automatic test_single_bit();
        logic [7:0] bits = 8'b1011_0010;
        $display("[TB] test_single_bit");
        for (int i = 0; i < 8; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = bits[7-i];
            bus1.in_sof   = (i == 0);
            step();
            if (i < 7) begin
                compared += 2;
                if (bus1.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL bit_early_valid: beat %0d got %b, expected 0", i, bus1.out_valid); end
                if (bus1.slot !== 3'(i + 1))  begin failed++; $display("[TB] FAIL bit_slot: beat %0d got %0d, expected %0d", i, bus1.slot, i + 1); end
            end
        end
        bus1.in_valid = 1'b0;
        bus1.in_sof   = 1'b0;
        compared += 3;
        if (bus1.out_valid !== 1'b1)  begin failed++; $display("[TB] FAIL bit_valid: got %b, expected 1", bus1.out_valid); end
        if (bus1.out_data !== 8'hB2)  begin failed++; $display("[TB] FAIL bit_word: got %h, expected b2", bus1.out_data); end
        if (bus1.slot !== 3'd0)       begin failed++; $display("[TB] FAIL bit_slot_wrap: got %0d, expected 0", bus1.slot); end
        step();
        compared++;
        if (bus1.out_valid !== 1'b0)  begin failed++; $display("[TB] FAIL bit_valid_pulse: got %b, expected 0", bus1.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w2 = 32'h9ABC_DEF0;
        $display("[TB] test_backpressure");
        bus4.out_ready = 1'b0;
        send_frame4(32'h1234_5678, 1'b1, 1'b0);
        idle4();
        compared += 2;
        if (bus4.out_valid !== 1'b1)        begin failed++; $display("[TB] FAIL bp_valid: got %b, expected 1", bus4.out_valid); end
        if (bus4.out_data !== 32'h12345678) begin failed++; $display("[TB] FAIL bp_word1: got %h, expected 12345678", bus4.out_data); end
        repeat (3) step();
        compared++;
        if (bus4.out_data !== 32'h12345678) begin failed++; $display("[TB] FAIL bp_hold: got %h, expected 12345678", bus4.out_data); end
        sb.push_back(w2);
        for (int i = 0; i < 7; i++) send_beat4(w2[31-4*i -: 4], (i == 0));
        bus4.in_valid = 1'b1;
        bus4.in_data  = w2[3:0];
        bus4.in_sof   = 1'b0;
        #1;
        compared++;
        if (bus4.in_ready !== 1'b0) begin failed++; $display("[TB] FAIL bp_stall: in_ready got %b, expected 0", bus4.in_ready); end
        for (int n = 0; n < 3; n++) begin
            step();
            compared++;
            if (acc4 !== 1'b0) begin failed++; $display("[TB] FAIL bp_accept: stalled beat accepted on cycle %0d, expected refusal", n); end
        end
        compared += 2;
        if (bus4.slot !== 3'd7)             begin failed++; $display("[TB] FAIL bp_slot: got %0d, expected 7", bus4.slot); end
        if (bus4.out_data !== 32'h12345678) begin failed++; $display("[TB] FAIL bp_hold2: got %h, expected 12345678", bus4.out_data); end
        bus4.out_ready = 1'b1;
        step();
        compared++;
        if (acc4 !== 1'b1) begin failed++; $display("[TB] FAIL bp_release: got accept %b, expected 1", acc4); end
        bus4.out_ready = 1'b0;
        idle4();
        compared += 2;
        if (bus4.out_valid !== 1'b1)        begin failed++; $display("[TB] FAIL bp_valid2: got %b, expected 1", bus4.out_valid); end
        if (bus4.out_data !== 32'h9ABCDEF0) begin failed++; $display("[TB] FAIL bp_word2: got %h, expected 9abcdef0", bus4.out_data); end
        bus4.out_ready = 1'b1;
        step();
        compared++;
        if (sb.size() !== 0) begin failed++; $display("[TB] FAIL bp_drain: queue holds %0d, expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int start;
        $display("[TB] test_back_to_back");
        bus4.out_ready = 1'b1;
        start = cycles;
        for (int f = 0; f < 4; f++) send_frame4(32'h0123_4567 + 32'(f) * 32'h1111_1111, (f == 0), 1'b0);
        idle4();
        compared++;
        if (cycles - start !== 32) begin failed++; $display("[TB] FAIL b2b_cycles: got %0d, expected 32", cycles - start); end
        step();
        compared += 2;
        if (sb.size() !== 0)          begin failed++; $display("[TB] FAIL b2b_drain: queue holds %0d, expected 0", sb.size()); end
        if (bus4.out_valid !== 1'b0)  begin failed++; $display("[TB] FAIL b2b_valid: got %b, expected 0", bus4.out_valid); end
    endtask

    task automatic test_sof_abort();
        logic [31:0] aborted = 32'h1122_3344;
        logic [31:0] w       = 32'hA123_4567;
        $display("[TB] test_sof_abort");
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_beat4(aborted[31-4*i -: 4], (i == 0));
        compared++;
        if (bus4.slot !== 3'd5) begin failed++; $display("[TB] FAIL sof_pre_slot: got %0d, expected 5", bus4.slot); end
        sb.push_back(w);
        send_beat4(4'hA, 1'b1);
        idle4();
        compared += 3;
        if (bus4.frame_err !== 1'b1) begin failed++; $display("[TB] FAIL sof_ferr: got %b, expected 1", bus4.frame_err); end
        if (bus4.slot !== 3'd1)      begin failed++; $display("[TB] FAIL sof_slot: got %0d, expected 1", bus4.slot); end
        if (bus4.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL sof_valid: got %b, expected 0", bus4.out_valid); end
        step();
        compared += 2;
        if (bus4.frame_err !== 1'b0) begin failed++; $display("[TB] FAIL sof_ferr_pulse: got %b, expected 0", bus4.frame_err); end
        if (bus4.slot !== 3'd1)      begin failed++; $display("[TB] FAIL sof_idle_slot: got %0d, expected 1", bus4.slot); end
        for (int i = 1; i < 8; i++) send_beat4(w[31-4*i -: 4], 1'b0);
        idle4();
        compared += 2;
        if (bus4.out_valid !== 1'b1) begin failed++; $display("[TB] FAIL sof_done: got %b, expected 1", bus4.out_valid); end
        if (bus4.out_data !== w)     begin failed++; $display("[TB] FAIL sof_word: got %h, expected %h", bus4.out_data, w); end
        step();
        compared++;
        if (sb.size() !== 0) begin failed++; $display("[TB] FAIL sof_drain: queue holds %0d, expected 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        logic [31:0] lost = 32'h0F0F_0F0F;
        $display("[TB] test_async_reset");
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat4(lost[31-4*i -: 4], (i == 0));
        for (int i = 0; i < 4; i++) send_beat4(4'(i + 1), (i == 0));
        idle4();
        compared += 2;
        if (bus4.out_valid !== 1'b1) begin failed++; $display("[TB] FAIL ar_pre_valid: got %b, expected 1", bus4.out_valid); end
        if (bus4.slot !== 3'd4)      begin failed++; $display("[TB] FAIL ar_pre_slot: got %0d, expected 4", bus4.slot); end
        #2;
        reset = 1'b1;
        #1;
        compared += 3;
        if (bus4.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL ar_valid: got %b, expected 0", bus4.out_valid); end
        if (bus4.slot !== 3'd0)      begin failed++; $display("[TB] FAIL ar_slot: got %0d, expected 0", bus4.slot); end
        if (bus4.out_data !== 32'h0) begin failed++; $display("[TB] FAIL ar_data: got %h, expected 0", bus4.out_data); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus4.out_ready = 1'b1;
        send_frame4(32'h5EC0_7D1A, 1'b1, 1'b0);
        idle4();
        step();
        compared += 2;
        if (sb.size() !== 0)         begin failed++; $display("[TB] FAIL ar_drain: queue holds %0d, expected 0", sb.size()); end
        if (bus4.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL ar_post_valid: got %b, expected 0", bus4.out_valid); end
    endtask

    task automatic test_random();
        int unused_seed;
        $display("[TB] test_random");
        unused_seed = $urandom(32'd20240611);
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) send_frame4($urandom, 1'($urandom_range(0, 1)), 1'b1);
        idle4();
        rand_ready = 1'b0;
        bus4.out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) step();
        step();
        compared++;
        if (sb.size() !== 0) begin failed++; $display("[TB] FAIL rand_drain: queue holds %0d, expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_backpressure();
        test_back_to_back();
        test_sof_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/dmux8way_deser.md
Name: dmux8way_deser

Overview:
- Receive-side counterpart of the 8-way selector. A lane-serial stream arrives one lane per accepted beat, and the block distributes the lanes into 8 parallel slots using an internal 3-bit slot counter.
- When 8 lanes are assembled, the word is presented on a registered valid/ready output.
- Sits between a lane-serial link and parallel consumers, in the same datapath layer as the existing 8-way mux.

Parameters:
- LANE_W, 1, bits per lane; the output word is 8*LANE_W bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  LANE_W  lane value.
- in_sof  input  1  marks the beat carrying lane 0 of a new frame.
- in_valid  input  1  in_data/in_sof are valid.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  8*LANE_W  assembled word; lane 0 in the most-significant LANE_W bits, lane 7 in the least.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer takes out_data this cycle.
- slot  output  3  index of the next lane to be written (0..7).
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (asynchronous, immediate):
  - slot=0, out_valid=0, out_data=0, frame_err=0.
  - Assembly register cleared; in_ready=1 once reset deasserts.
  - Reset mid-frame discards the partial word and any pending output word.
- Accept: beat accepted when in_valid && in_ready.
- in_ready is combinational: in_ready = !(slot==7 && out_valid && !out_ready). The block stalls only when the final lane cannot be transferred.
- Accepted beat, no framing error:
  - Write assembly lane[slot] = in_data.
  - slot increments, wrapping 7 -> 0.
- Completion (accepted beat with slot==7):
  - Next edge: out_data = {lanes 0..6, in_data}, out_valid=1, slot=0.
  - Latency: last lane in -> out_valid high 1 cycle later.
- Output handshake:
  - out_valid && out_ready clears out_valid unless a new completion occurs in the same cycle; in that case out_valid stays 1 and out_data takes the new word. No bubble, no loss.
  - out_data is held stable while out_valid && !out_ready.
- Framing:
  - Accepted beat with in_sof=1 and slot!=0: discard the partial word, write in_data to lane 0, set slot=1, pulse frame_err for one cycle.
  - Accepted beat with in_sof=1 and slot==0: normal.
  - Accepted beat with in_sof=0 and slot==0: accepted normally. sof is optional for back-to-back frames.
- Beats with in_valid=0 change nothing; slot holds.
- frame_err is registered, asserted on the edge after the offending beat, and low otherwise.
- Simultaneous stall and sof with slot==7: the beat is not accepted, so no error and no state change.
- No X-propagation: lanes not yet written in the current frame hold their previous values, which are never visible because out_data updates only on completion.

Test Plan:
- Reset, then 8 consecutive beats with LANE_W=1, bits 1,0,1,1,0,0,1,0 (sof on first), out_ready=1 -> out_data=8'hB2, out_valid high exactly 1 cycle, 1 cycle after the 8th beat; slot returns to 0.
- LANE_W=4, lanes 0x1..0x8, out_ready=0 -> out_valid=1, out_data=32'h12345678 held. Second frame 0x9..0x0 (lanes 0x9,0xA..0xF,0x0): in_ready drops at slot 7 until out_ready pulses, then word 2 is captured with none lost.
- Back-to-back frames with out_ready=1 continuously -> one out_valid per 8 beats, zero stall cycles, in_ready constantly 1.
- sof asserted at slot 5 with in_data=0xA -> frame_err pulses 1 cycle, slot=1, next 7 beats complete a word with lane 0 = 0xA; no word emitted for the aborted frame.
- reset asserted asynchronously at slot 4 with out_valid=1 -> out_valid=0 and slot=0 before the next clock edge; the following frame assembles correctly.
- Random in_valid/out_ready gaps (seeded, 1000 frames) -> scoreboard matches all words in order, no drops or duplicates.
